// File: rtl/exu_wbu_stage_pkg.sv
// ---------------------------------------------------------------------------
// exu_wbu_stage_pkg
// Shared definitions for the execute-to-writeback stage:
//   XLEN / RADDR_W   default datapath and register-index widths
//   wb_entry_t       one register-writeback entry {rd_addr, wen, data}
//   ST_EMPTY/BUSY/FULL  handshake FSM encoding used by 2-entry skid buffers
// ---------------------------------------------------------------------------
package exu_wbu_stage_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef struct packed {
        logic [RADDR_W-1:0] rd_addr;
        logic               wen;
        logic [XLEN-1:0]    data;
    } wb_entry_t;

    // Occupancy of a 2-entry skid buffer.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/exu_wbu_stage_skid.sv
// ---------------------------------------------------------------------------
// wb_skid_buffer
// Generic 2-entry valid/ready skid buffer carrying wb_entry_t.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_entry_i    upstream handshake + payload
//   out_valid_o/out_ready_i/out_entry_o downstream handshake + head entry
// in_ready_o is a flop: it only reflects the occupancy after the last edge,
// so there is no combinational path from out_ready_i back upstream.
// ---------------------------------------------------------------------------
module wb_skid_buffer
    import exu_wbu_stage_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      in_valid_i,
    output logic      in_ready_o,
    input  wb_entry_t in_entry_i,
    output logic      out_valid_o,
    input  logic      out_ready_i,
    output wb_entry_t out_entry_o
);

    logic [1:0] state_q, state_d;
    wb_entry_t  main_q, main_d;
    wb_entry_t  skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic       in_fire, out_fire;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_entry_o = main_q;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        in_fire    = in_valid_i & in_ready_q;
        out_fire   = (state_q != ST_EMPTY) & out_ready_i;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_entry_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_entry_i;
                end else if (in_fire) begin
                    // Head is stalled: park the newcomer behind it.
                    skid_d  = in_entry_i;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/exu_wbu_stage.sv
// ---------------------------------------------------------------------------
// exu_wbu_stage
// Execute-to-writeback stage. Computes the jal/jalr link value and the
// redirect target, registers a one-cycle PC redirect pulse, kills the
// wrong-path instruction that arrives while that pulse is high, and forwards
// writeback entries to the WBU through a 2-entry skid buffer.
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   in_valid_i / in_ready_o              upstream handshake
//   pc_i, imm_i, rs1_data_i, rd_data_i   operands / ALU result
//   pc_imm_ctrl_i, jal_ctrl_i, jalr_ctrl_i  control-flow decode
//   rd_addr_i, rd_wen_i                  destination register
//   out_valid_o / out_ready_i            WBU handshake
//   out_rd_addr_o, out_rd_wen_o, out_rd_data_o  head writeback entry
//   redirect_valid_o, redirect_pc_o      PC redirect pulse + target
// ---------------------------------------------------------------------------
module exu_wbu_stage
    import exu_wbu_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RADDR_W      = 5,
    parameter int RESET_PC_NOP = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rd_data_i,
    input  logic               pc_imm_ctrl_i,
    input  logic               jal_ctrl_i,
    input  logic               jalr_ctrl_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               rd_wen_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [RADDR_W-1:0] out_rd_addr_o,
    output logic               out_rd_wen_o,
    output logic [XLEN-1:0]    out_rd_data_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o
);

    // Reserved parameter, intentionally without functional effect.
    if (RESET_PC_NOP != 0) begin : g_reset_pc_nop_reserved
    end

    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            in_fire;
    logic            push_valid;
    logic            is_redirect;
    logic [XLEN-1:0] link_pc;
    logic [XLEN-1:0] target_pc;
    wb_entry_t       in_entry;
    wb_entry_t       head_entry;

    assign in_fire = in_valid_i & in_ready_o;

    // The instruction right behind a redirect is on the wrong path: it is
    // handshaken upstream (ready is honoured) but never reaches the buffer.
    assign push_valid = in_valid_i & ~redirect_valid_q;

    always_comb begin
        link_pc     = pc_i + XLEN'(4);
        is_redirect = jal_ctrl_i | jalr_ctrl_i | pc_imm_ctrl_i;
        // jalr wins over jal/branch; jal and branch share pc+imm.
        if (jalr_ctrl_i) begin
            target_pc = (rs1_data_i + imm_i) & ~XLEN'(1);
        end else begin
            target_pc = pc_i + imm_i;
        end

        in_entry.rd_addr = rd_addr_i;
        in_entry.wen     = rd_wen_i & (rd_addr_i != '0);
        in_entry.data    = (jal_ctrl_i | jalr_ctrl_i) ? link_pc : rd_data_i;

        redirect_valid_d = in_fire & ~redirect_valid_q & is_redirect;
        redirect_pc_d    = redirect_valid_d ? target_pc : redirect_pc_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    wb_skid_buffer u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (push_valid),
        .in_ready_o  (in_ready_o),
        .in_entry_i  (in_entry),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_entry_o (head_entry)
    );

    assign out_rd_addr_o    = head_entry.rd_addr;
    assign out_rd_wen_o     = head_entry.wen;
    assign out_rd_data_o    = head_entry.data;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_exu_wbu_stage.sv
module tb_exu_wbu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc = '0, imm = '0, rs1 = '0, rd_data = '0;
    logic        br = 1'b0, jal = 1'b0, jalr = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic        rd_wen = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wen;
    logic [31:0] out_rd_data;
    logic        redir_valid;
    logic [31:0] redir_pc;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  a;
        logic        w;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic        m_rv  = 1'b0;
    logic [31:0] m_rpc = '0;

    always #5 clk = ~clk;

    exu_wbu_stage #(.XLEN(32), .RADDR_W(5), .RESET_PC_NOP(0)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .pc_i             (pc),
        .imm_i            (imm),
        .rs1_data_i       (rs1),
        .rd_data_i        (rd_data),
        .pc_imm_ctrl_i    (br),
        .jal_ctrl_i       (jal),
        .jalr_ctrl_i      (jalr),
        .rd_addr_i        (rd_addr),
        .rd_wen_i         (rd_wen),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_rd_addr_o    (out_rd_addr),
        .out_rd_wen_o     (out_rd_wen),
        .out_rd_data_o    (out_rd_data),
        .redirect_valid_o (redir_valid),
        .redirect_pc_o    (redir_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, q[0].a});
            chk("out_rd_wen", {31'd0, out_rd_wen}, {31'd0, q[0].w});
            chk("out_rd_data", out_rd_data, q[0].d);
        end
        chk("redirect_valid", {31'd0, redir_valid}, {31'd0, m_rv});
        chk("redirect_pc", redir_pc, m_rpc);
    endtask

    // Reference model: a FIFO of at most two writeback entries plus the
    // expected redirect pulse, advanced once per clock from the current inputs.
    task automatic cycle();
        bit   fire, ofire, new_rv;
        exp_t e;
        fire   = in_valid && (q.size() < 2);
        ofire  = (q.size() > 0) && out_ready;
        new_rv = 1'b0;
        if (ofire) void'(q.pop_front());
        if (fire && !m_rv) begin
            e.a = rd_addr;
            e.w = rd_wen && (rd_addr != 5'd0);
            e.d = (jal || jalr) ? pc + 32'd4 : rd_data;
            q.push_back(e);
            if (jalr) begin
                new_rv = 1'b1;
                m_rpc  = (rs1 + imm) & 32'hFFFF_FFFE;
            end else if (jal || br) begin
                new_rv = 1'b1;
                m_rpc  = pc + imm;
            end
        end
        m_rv = new_rv;
        @(posedge clk);
        #1;
        $display("cyc t=%0t in_v=%0b rdy=%0b out_v=%0b rd=%0d d=%h redir=%0b pc=%h",
                 $time, in_valid, in_ready, out_valid, out_rd_addr, out_rd_data, redir_valid, redir_pc);
        check_all();
    endtask

    task automatic set_alu(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1; rd_addr = a; rd_data = d; rd_wen = 1'b1;
        br = 1'b0; jal = 1'b0; jalr = 1'b0;
        pc = 32'h1000; imm = 32'h0; rs1 = 32'h0;
    endtask

    task automatic idle();
        in_valid = 1'b0; br = 1'b0; jal = 1'b0; jalr = 1'b0;
    endtask

    initial begin
        bit          hold;
        int unsigned r;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all();

        // Streaming: 4 back-to-back ALU ops
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_alu(5'(i), 32'(i * 32'h11));
            cycle();
            chk("stream_data", out_rd_data, 32'(i * 32'h11));
        end
        idle();
        repeat (2) cycle();

        // Backpressure: two accepted, third held until space frees
        out_ready = 1'b0;
        set_alu(5'd7, 32'hA1); cycle();
        set_alu(5'd8, 32'hA2); cycle();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        set_alu(5'd9, 32'hA3); cycle(); cycle();
        out_ready = 1'b1;
        cycle(); cycle();
        idle();
        repeat (3) cycle();

        // Taken branch, then a wrong-path instruction that must be dropped
        set_alu(5'd5, 32'h55);
        pc = 32'h8000_0010; imm = 32'hFFFF_FFF0; br = 1'b1;
        cycle();
        chk("branch_redir_pc", redir_pc, 32'h8000_0000);
        chk("branch_redir_v", {31'd0, redir_valid}, 32'd1);
        set_alu(5'd6, 32'h66);
        cycle();
        chk("branch_pulse_end", {31'd0, redir_valid}, 32'd0);
        idle();
        repeat (2) cycle();

        // jalr
        set_alu(5'd1, 32'hDEAD);
        pc = 32'h100; rs1 = 32'h8000_1003; imm = 32'h4; jalr = 1'b1;
        cycle();
        chk("jalr_target", redir_pc, 32'h8000_1006);
        chk("jalr_link", out_rd_data, 32'h104);
        chk("jalr_wen", {31'd0, out_rd_wen}, 32'd1);
        idle();
        repeat (2) cycle();

        // rd=0 suppresses write enable
        set_alu(5'd0, 32'h77);
        cycle();
        chk("rd0_wen", {31'd0, out_rd_wen}, 32'd0);
        idle(); cycle();

        // jal link wraps around
        set_alu(5'd2, 32'h0);
        pc = 32'hFFFF_FFFC; imm = 32'h8; jal = 1'b1;
        cycle();
        chk("jal_wrap_link", out_rd_data, 32'h0);
        idle();
        repeat (2) cycle();

        // Async reset while FULL with a redirect pending
        out_ready = 1'b0;
        set_alu(5'd3, 32'h33); cycle();
        set_alu(5'd4, 32'h0); pc = 32'h200; imm = 32'h40; jal = 1'b1; cycle();
        idle();
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_redir_valid", {31'd0, redir_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete(); m_rv = 1'b0; m_rpc = '0;
        #1 check_all();

        // Randomized traffic with stable inputs while stalled
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rd_addr  = 5'($urandom_range(0, 7));
                rd_wen   = $urandom_range(0, 1) == 1;
                rd_data  = $urandom;
                pc       = $urandom;
                imm      = $urandom;
                rs1      = $urandom;
                r        = $urandom_range(0, 9);
                br       = (r == 0) || (r == 3);
                jal      = (r == 1) || (r == 3);
                jalr     = (r == 2) || (r == 3);
            end
            hold = in_valid && !in_ready;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exu_wbu_stage.md
Name: exu_wbu_stage

Overview:
- Execute-to-writeback pipeline stage. It sits directly downstream of the ALU result handler.
- Registers the ALU result and the branch decision (pc_imm_ctrl), and generates a one-cycle PC redirect.
- Substitutes the link value (pc+4) for jal/jalr.
- Forwards register-writeback data to the WBU through a 2-entry skid buffer with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, datapath width
- RADDR_W, 5, register index width
- RESET_PC_NOP, 0, reserved; no functional effect, tied off

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  upstream instruction valid
- in_ready_o  out  1  stage can accept
- pc_i  in  XLEN  instruction PC
- imm_i  in  XLEN  decoded immediate
- rs1_data_i  in  XLEN  rs1 operand (jalr base)
- rd_data_i  in  XLEN  ALU result (already slt-resolved)
- pc_imm_ctrl_i  in  1  conditional branch taken
- jal_ctrl_i  in  1  jal instruction
- jalr_ctrl_i  in  1  jalr instruction
- rd_addr_i  in  RADDR_W  destination register
- rd_wen_i  in  1  writeback enable
- out_valid_o  out  1  writeback entry valid
- out_ready_i  in  1  WBU accepts
- out_rd_addr_o  out  RADDR_W  head entry rd
- out_rd_wen_o  out  1  head entry write enable (0 forced when rd_addr==0)
- out_rd_data_o  out  XLEN  head entry data
- redirect_valid_o  out  1  PC redirect pulse
- redirect_pc_o  out  XLEN  redirect target

Behaviour:
- Reset (async, rst_i=1): state EMPTY; out_valid_o=0, out_rd_addr_o=0, out_rd_wen_o=0, out_rd_data_o=0, redirect_valid_o=0, redirect_pc_o=0, in_ready_o=1 once released.
- Accept: in_fire = in_valid_i & in_ready_o. Output transfer: out_fire = out_valid_o & out_ready_i.
- Skid buffer FSM states:
  - EMPTY (0 entries): in_fire -> BUSY.
  - BUSY (main register holds 1): in_fire & !out_fire -> FULL; !in_fire & out_fire -> EMPTY; both or neither -> BUSY.
  - FULL (main + skid hold 2): out_fire -> BUSY, skid moves to main. in_ready_o=0 in FULL.
- in_ready_o is a registered signal: 1 in EMPTY/BUSY, 0 in FULL. No combinational path from out_ready_i.
- Latency: an accepted entry appears on out_* the cycle after in_fire when the buffer was empty. Order is strictly FIFO.
- Writeback data:
  - jal_ctrl_i | jalr_ctrl_i -> pc_i+4 (mod 2^32).
  - Otherwise rd_data_i.
  - Stored wen = rd_wen_i & (rd_addr_i != 0).
- Redirect target (all arithmetic mod 2^32):
  - jalr -> (rs1_data_i+imm_i) & ~1.
  - jal or pc_imm_ctrl_i -> pc_i+imm_i.
  - Priority when more than one is set: jalr > jal > branch.
- Redirect timing: redirect_valid_o is registered, high exactly the cycle after the in_fire of a redirecting instruction, for one cycle. It does not depend on output backpressure. redirect_pc_o holds its last value when not valid.
- Wrong-path kill: an in_fire occurring in a cycle where redirect_valid_o=1 is consumed (in_ready honoured) but discarded. It does not enter the buffer and cannot itself redirect.
- Full + in_valid: no accept; upstream holds its inputs stable.
- Reset mid-operation: all buffered entries are dropped and any pending redirect is cancelled immediately.

Decomposition:
- Shared package: XLEN, RADDR_W, and a writeback-entry struct {rd_addr, wen, data}. The team-wide handshake FSM encoding (EMPTY/BUSY/FULL) also lives there.
- One natural sub-module: wb_skid_buffer, a generic 2-entry valid/ready skid buffer on the entry struct.
- The top level holds link/target arithmetic, the redirect register and the kill logic.

Test Plan:
- Streaming: out_ready_i=1, 4 back-to-back ALU ops rd=1..4, data 0x11..0x44 -> same sequence on out, 1-cycle latency, in_ready_o stays 1.
- Backpressure: out_ready_i=0, send 3 entries -> first 2 accepted (state FULL, in_ready_o=0), third held. Raise out_ready_i -> all 3 delivered in order, none lost or duplicated.
- Branch taken, pc=0x80000010, imm=0xFFFFFFF0, pc_imm_ctrl=1 -> redirect_valid_o pulse 1 cycle, redirect_pc_o=0x80000000. Next cycle's input is discarded.
- jalr, rs1=0x80001003, imm=0x4, rd=1 -> redirect_pc_o=0x80001006; out_rd_data_o=pc+4; out_rd_wen_o=1.
- rd=0 with rd_wen_i=1 -> out_rd_wen_o=0. Wrap case: pc=0xFFFFFFFC with jal -> link value 0x00000000.
- Assert rst_i asynchronously while FULL with a redirect pending -> out_valid_o=0 and redirect_valid_o=0 immediately (before the next clock edge), in_ready_o=1 after release.
